// File: rtl/alu4_host_pkg.sv
// Purpose: shared types and constants for the ALU4 host-side pin driver.
// Latency: n/a (types, constants and pure pin-packing helpers only).
// Backpressure: n/a.
package alu4_host_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // Field offsets inside the dedicated input bus (ui_in).
    localparam int UI_A_LSB    = 0;
    localparam int UI_B_LSB    = 4;
    // Field offsets inside the bidirectional input bus (uio_in).
    localparam int UIO_OP_LSB  = 0;
    localparam int UIO_CIN_BIT = 4;

    localparam int DEF_LATENCY      = 2;
    localparam int DEF_RESET_CYCLES = 4;

    function automatic logic [7:0] pack_ui(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] v;
        v = '0;
        v[UI_A_LSB +: 4] = a;
        v[UI_B_LSB +: 4] = b;
        return v;
    endfunction

    // Upper three uio bits are not used by the ALU and are always driven low.
    function automatic logic [7:0] pack_uio(input logic [3:0] op, input logic cin);
        logic [7:0] v;
        v = '0;
        v[UIO_OP_LSB +: 4] = op;
        v[UIO_CIN_BIT]     = cin;
        return v;
    endfunction

endpackage

// File: rtl/alu4_host_checker.sv
// Purpose: holds the expected uo_out of the current command, flags a mismatch, counts mismatches (saturating at 255).
// Latency: expected value registered on accept; mismatch registered on capture; count updates on the response handshake.
// Backpressure: none; it follows the strobes of the driver FSM. Only compiled when ALU4_HOST_CHECK_EN is defined.
`ifdef ALU4_HOST_CHECK_EN
module alu4_host_checker
    import alu4_host_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] exp_dat,
    input  logic       capture,
    input  logic [7:0] obs_dat,
    input  logic       rsp_hs,
    output logic       mismatch,
    output logic [7:0] err_count
);

    logic [7:0] exp_q;

    // Latch the expected value with the command so the cmd port can move on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q <= '0;
        end else if (load) begin
            exp_q <= exp_dat;
        end
    end

    // Compare on the same edge the response data is captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
        end else if (capture) begin
            mismatch <= (obs_dat != exp_q);
        end
    end

    // Count each mismatching response once, at its handshake; stick at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (rsp_hs && mismatch && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule
`endif

// File: rtl/alu4_host_driver.sv
// Purpose: drives ALU4 pins from a valid/ready command, sequences DUT reset, returns sampled uo_out (check option: ALU4_HOST_CHECK_EN).
// Latency: pins valid after accept edge E0, rsp_valid after E0+LATENCY+1, cmd_ready again after E0+LATENCY+2 with rsp_ready high.
// Backpressure: one command in flight; cmd_ready low outside IDLE, response held until rsp_ready.
module alu4_host_driver
    import alu4_host_pkg::*;
#(
    parameter int LATENCY      = DEF_LATENCY,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_op,
    input  logic       cmd_cin,
    input  logic [7:0] cmd_exp,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       rsp_mismatch,
    output logic [7:0] dut_ui_in,
    output logic [7:0] dut_uio_in,
    input  logic [7:0] dut_uo_out,
    input  logic [7:0] dut_uio_oe,
    output logic       dut_ena,
    output logic       dut_rst_n,
    output logic       pin_conflict,
    output logic [7:0] err_count
);

    localparam logic [7:0] RST_LAST = 8'(RESET_CYCLES);
    localparam logic [3:0] LAT_LAST = 4'(LATENCY - 1);

    state_t     state_q;
    state_t     state_d;
    logic [7:0] rst_cnt_q;
    logic [3:0] lat_cnt_q;
    logic       accept;
    logic       capture;
    logic       rsp_hs;
    logic       wait_done;
    logic       drv_phase;

    assign wait_done = (lat_cnt_q == LAT_LAST);
    assign drv_phase = (state_q == ST_DRIVE) || (state_q == ST_WAIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic plus handshake strobes decoded from the current state.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_hs    = 1'b0;
        unique case (state_q)
            // Leave one cycle after dut_rst_n rises before taking commands.
            ST_RESET: if (dut_rst_n) state_d = ST_IDLE;
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (wait_done) begin
                    capture = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rsp_hs  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    // DUT reset sequencing: enable on the first edge, release reset once the count is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q <= '0;
            dut_rst_n <= 1'b0;
            dut_ena   <= 1'b0;
        end else if (state_q == ST_RESET) begin
            dut_ena <= 1'b1;
            if (rst_cnt_q == RST_LAST) begin
                dut_rst_n <= 1'b1;
            end else begin
                rst_cnt_q <= rst_cnt_q + 8'd1;
            end
        end
    end

    // Settle counter: cleared while pins go stable, advanced through WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_cnt_q <= '0;
        end else if (state_q == ST_DRIVE) begin
            lat_cnt_q <= '0;
        end else if ((state_q == ST_WAIT) && !wait_done) begin
            lat_cnt_q <= lat_cnt_q + 4'd1;
        end
    end

    // Pin registers load on accept and otherwise keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_ui_in  <= '0;
            dut_uio_in <= '0;
        end else if (accept) begin
            dut_ui_in  <= pack_ui(cmd_a, cmd_b);
            dut_uio_in <= pack_uio(cmd_op, cmd_cin);
        end
    end

    // Response data is captured once and held through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data <= '0;
        end else if (capture) begin
            rsp_data <= dut_uo_out;
        end
    end

    // Sticky flag: DUT enables an output on a pin we are driving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pin_conflict <= 1'b0;
        end else if (drv_phase && (dut_uio_oe[4:0] != 5'd0)) begin
            pin_conflict <= 1'b1;
        end
    end

`ifdef ALU4_HOST_CHECK_EN
    alu4_host_checker u_checker (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .exp_dat   (cmd_exp),
        .capture   (capture),
        .obs_dat   (dut_uo_out),
        .rsp_hs    (rsp_hs),
        .mismatch  (rsp_mismatch),
        .err_count (err_count)
    );

    logic unused_oe_hi;
    assign unused_oe_hi = ^dut_uio_oe[7:5];
`else
    assign rsp_mismatch = 1'b0;
    assign err_count    = 8'd0;

    logic unused_inputs;
    assign unused_inputs = ^{cmd_exp, dut_uio_oe[7:5]};
`endif

endmodule

// File: doc/alu4_host_driver.md
# alu4_host_driver

Synthesizable host-side driver for the TinyTapeout ALU4 pin interface. It accepts ALU commands on a valid/ready port and sequences the DUT reset. It drives `ui_in`/`uio_in`, waits a configurable settle latency, samples `uo_out`, and returns the result on a valid/ready response port. It sits in the FPGA/loopback harness on the opposite side of the pin bundle from `tt_um_dlmiles_alu4`.

## Interface
- `LATENCY`, 2, cycles from pins driven to `uo_out` sampled; range 1..15.
- `RESET_CYCLES`, 4, cycles `dut_rst_n` is held low after our reset release; range 1..255.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1; `cmd_ready` out 1: command handshake.
- `cmd_a` in 4; `cmd_b` in 4; `cmd_op` in 4; `cmd_cin` in 1: operands, opcode and carry-in.
- `cmd_exp` in 8: expected `uo_out`; used only when checking is compiled in.
- `rsp_valid` out 1; `rsp_ready` in 1: response handshake.
- `rsp_data` out 8: captured `uo_out`.
- `rsp_mismatch` out 1: `rsp_data != cmd_exp` (check build only).
- `dut_ui_in` out 8; `dut_uio_in` out 8: driven DUT inputs.
- `dut_uo_out` in 8; `dut_uio_oe` in 8: DUT outputs.
- `dut_ena` out 1; `dut_rst_n` out 1: DUT enable and reset.
- `pin_conflict` out 1: sticky flag, set when `dut_uio_oe[4:0]` != 0 while the driver is driving those pins.
- `err_count` out 8: saturating mismatch count (check build only).

## Operation
- Pin map:
  - `dut_ui_in` = {`cmd_b`, `cmd_a`}.
  - `dut_uio_in` = {3'b000, `cmd_cin`, `cmd_op`}.
- All pin outputs are registered.
- States: RESET, IDLE, DRIVE, WAIT, RESP.
- RESET:
  - `dut_rst_n`=0, `dut_ena`=1.
  - A counter counts `RESET_CYCLES`, then the block releases `dut_rst_n`=1 and goes to IDLE.
- IDLE:
  - `cmd_ready`=1, decoded combinationally from state.
  - On `cmd_valid`&&`cmd_ready`, load the pin registers and `cmd_exp`, then go to DRIVE.
- DRIVE: pins are stable. Clear the latency counter and go to WAIT.
- WAIT:
  - Count `LATENCY` edges.
  - On the final edge, capture `dut_uo_out` into `rsp_data`, compute `rsp_mismatch`, set `rsp_valid`, and go to RESP.
- RESP:
  - Hold `rsp_valid`, `rsp_data` and `rsp_mismatch` until `rsp_ready`.
  - On the handshake, go to IDLE.
- `cmd_ready`=0 in every state except IDLE. No command is accepted in the cycle of a response handshake.
- Pins keep their last driven values in IDLE; they do not return to 0.
- `pin_conflict` is checked in DRIVE and WAIT only. Once set, it stays set until `rst_n`.
- `err_count` increments on each response handshake with `rsp_mismatch`=1 and saturates at 255.

## Timing
- Reset values:
  - `cmd_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_mismatch`=0.
  - `dut_ui_in`=0, `dut_uio_in`=0, `dut_rst_n`=0, `dut_ena`=0.
  - `pin_conflict`=0, `err_count`=0.
  - State = RESET.
- Edge after reset release: `dut_ena`=1.
- `dut_rst_n` rises `RESET_CYCLES` edges after the first clock edge out of reset.
- Accept edge E0: pins are valid after E0.
- `rsp_valid` rises after edge E0+`LATENCY`+1.
- With `rsp_ready` held high, a full transaction takes `LATENCY`+3 cycles (`cmd_ready` high again after edge E0+`LATENCY`+2).
- `rsp_ready` is allowed high before `rsp_valid`; it takes effect only in RESP.
- `rst_n` asserted mid-transaction: all outputs drop to reset values immediately (asynchronous), and the RESET sequence restarts.

## Configuration
- `ALU4_HOST_CHECK_EN` defined:
  - `cmd_exp` is registered.
  - `rsp_mismatch` and `err_count` are live.
- Undefined:
  - `cmd_exp` is ignored.
  - `rsp_mismatch` and `err_count` are tied to 0; no compare or counter logic is present.

## Structure
- Package `alu4_host_pkg` holds:
  - the state enum;
  - pin field offsets (A, B, OP, CIN);
  - default `LATENCY`/`RESET_CYCLES` constants.
- Sub-module `alu4_host_checker`: registered expected value, comparator and saturating `err_count`. It is instantiated only under `ALU4_HOST_CHECK_EN`.

## Test plan
- Reset, `RESET_CYCLES`=4: `dut_rst_n` is low for 4 edges, then 1; `cmd_ready` rises the following cycle.
- Command a=3, b=5, op=0, cin=0, with the loopback model forcing `uo_out`=8'h08:
  - `dut_ui_in`=8'h53 and `dut_uio_in`=8'h00.
  - `rsp_valid` after E0+3 (`LATENCY`=2) with `rsp_data`=8'h08.
- `rsp_ready` held low for 5 cycles: `rsp_valid`/`rsp_data` stay stable, `cmd_ready` stays 0, and a second `cmd_valid` is not accepted.
- Check build, `cmd_exp`=8'h09 vs `uo_out`=8'h08: `rsp_mismatch`=1 and `err_count` goes 0→1. After 300 mismatching commands, `err_count`=255.
- `dut_uio_oe`=8'h01 during WAIT: `pin_conflict`=1 and it stays 1 through later clean commands until `rst_n`.
- `rst_n` pulsed low during WAIT: outputs return to reset values at once, no `rsp_valid` appears, and the RESET sequence repeats.
